// File: rtl/regfile_write_buffer.sv
// FIFO write buffer in front of the MIPS 32x32 register file write port.
// Queued writes drain one per cycle, and pending values are forwarded to both read ports.
module regfile_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [4:0]  InRegister,
    input  logic [31:0] InData,
    input  logic        DrainEnable,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        RegWrite,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    input  logic [31:0] RegData1,
    input  logic [31:0] RegData2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic [4:0]  Occupancy
);

    localparam int         PTR_W = $clog2(DEPTH);
    localparam logic [4:0] FULL  = 5'(DEPTH);

    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [4:0]       r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_nonempty;
    logic [31:0]      w_rd1;
    logic [31:0]      w_rd2;
    logic [PTR_W-1:0] w_idx;

    assign w_nonempty = (r_count != 5'd0);
    assign InReady    = (r_count != FULL);
    // Writes to register 0 complete the handshake but are never stored.
    assign w_push     = InValid & InReady & (InRegister != 5'd0);
    assign w_pop      = DrainEnable & w_nonempty;

    assign RegWrite      = w_pop;
    assign WriteRegister = w_nonempty ? r_addr[r_head] : 5'd0;
    assign WriteData     = w_nonempty ? r_data[r_head] : 32'd0;
    assign Occupancy     = r_count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 5'd0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_addr[r_tail] <= InRegister;
            r_data[r_tail] <= InData;
        end
    end

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_rd1 = RegData1;
        w_rd2 = RegData2;
        w_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if (5'(k) < r_count) begin
                if ((ReadRegister1 != 5'd0) && (r_addr[w_idx] == ReadRegister1))
                    w_rd1 = r_data[w_idx];
                if ((ReadRegister2 != 5'd0) && (r_addr[w_idx] == ReadRegister2))
                    w_rd2 = r_data[w_idx];
            end
        end
    end

    assign ReadData1 = w_rd1;
    assign ReadData2 = w_rd2;

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: queue-based reference model, a bench-owned
// register file on the write port, directed scenarios and a randomized phase.
module tb_regfile_write_buffer;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [4:0]  InRegister;
    logic [31:0] InData;
    logic        DrainEnable;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] RegData1;
    logic [31:0] RegData2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [4:0]  Occupancy;

    regfile_write_buffer #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InRegister(InRegister), .InData(InData), .DrainEnable(DrainEnable),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .RegData1(RegData1), .RegData2(RegData2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .Occupancy(Occupancy)
    );

    always #5 Clk = ~Clk;

    // Register file driven by the DUT write port; register 0 reads as zero.
    logic [31:0] rf   [32] = '{8: 32'h1234_5678, default: 32'h0};
    // Register file contents the model says must have been written.
    logic [31:0] rf_m [32] = '{8: 32'h1234_5678, default: 32'h0};

    always @(posedge Clk) begin
        if (RegWrite) rf[WriteRegister] <= WriteData;
    end
    assign RegData1 = (ReadRegister1 == 5'd0) ? 32'd0 : rf[ReadRegister1];
    assign RegData2 = (ReadRegister2 == 5'd0) ? 32'd0 : rf[ReadRegister2];

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    ent_t m_e;
    bit   m_acc;
    bit   m_drn;

    // Reference model: pending writes are a plain FIFO queue.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q.delete();
        end else begin
            m_acc = InValid && (q.size() < DEPTH);
            m_drn = DrainEnable && (q.size() != 0);
            if (m_drn) begin
                m_e = q.pop_front();
                rf_m[m_e.a] = m_e.d;
            end
            if (m_acc && (InRegister != 5'd0)) q.push_back('{InRegister, InData});
        end
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        logic [31:0] v;
        v = (ra == 5'd0) ? 32'd0 : rf_m[ra];
        if (ra != 5'd0)
            foreach (q[i]) if (q[i].a == ra) v = q[i].d;
        return v;
    endfunction

    always @(negedge Clk) begin
        chk("occupancy", 32'(Occupancy), 32'(q.size()));
        chk("in_ready", 32'(InReady), 32'(q.size() != DEPTH));
        chk("reg_write", 32'(RegWrite), 32'(DrainEnable && (q.size() != 0)));
        chk("write_register", 32'(WriteRegister), (q.size() != 0) ? 32'(q[0].a) : 32'd0);
        chk("write_data", WriteData, (q.size() != 0) ? q[0].d : 32'd0);
        chk("read_data1", ReadData1, exp_rd(ReadRegister1));
        chk("read_data2", ReadData2, exp_rd(ReadRegister2));
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        InValid = 1'b1; InRegister = a; InData = d;
        step();
        InValid = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; InValid = 1'b0; InRegister = 5'd0; InData = 32'd0;
        DrainEnable = 1'b0; ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        repeat (2) step();
        Reset = 1'b0;

        // Reset state
        chk("rst_occ", 32'(Occupancy), 32'd0);
        chk("rst_ready", 32'(InReady), 32'd1);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_waddr", 32'(WriteRegister), 32'd0);
        chk("rst_wdata", WriteData, 32'd0);

        // Single write with drain enabled
        DrainEnable = 1'b1;
        push(5'd5, 32'hDEAD_BEEF);
        chk("single_regwrite", 32'(RegWrite), 32'd1);
        chk("single_waddr", 32'(WriteRegister), 32'd5);
        chk("single_wdata", WriteData, 32'hDEAD_BEEF);
        chk("single_occ1", 32'(Occupancy), 32'd1);
        step();
        chk("single_occ0", 32'(Occupancy), 32'd0);
        chk("single_rf5", rf[5], 32'hDEAD_BEEF);

        // Fill with drain disabled, fifth request stalls until a pop
        DrainEnable = 1'b0;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'(100 + i));
        InValid = 1'b1; InRegister = 5'd9; InData = 32'h99;
        chk("full_occ", 32'(Occupancy), 32'd4);
        chk("full_ready", 32'(InReady), 32'd0);
        step();
        chk("full_hold_occ", 32'(Occupancy), 32'd4);
        DrainEnable = 1'b1;
        step();
        chk("full_pop_occ", 32'(Occupancy), 32'd3);
        chk("full_pop_ready", 32'(InReady), 32'd1);
        chk("full_pop_head", 32'(WriteRegister), 32'd2);
        step();
        InValid = 1'b0;
        chk("full_accept_occ", 32'(Occupancy), 32'd3);
        repeat (4) step();
        chk("full_drained", 32'(Occupancy), 32'd0);
        chk("full_rf9", rf[9], 32'h99);

        // Forwarding of the youngest pending write
        DrainEnable = 1'b0;
        push(5'd7, 32'h11);
        push(5'd7, 32'h22);
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd8;
        #1;
        chk("fwd_youngest", ReadData1, 32'h22);
        chk("fwd_passthru", ReadData2, 32'h1234_5678);
        DrainEnable = 1'b1;
        step();
        chk("fwd_one_left", ReadData1, 32'h22);
        step();
        chk("fwd_retired", ReadData1, 32'h22);
        chk("fwd_retired_occ", 32'(Occupancy), 32'd0);

        // Register 0 is accepted but never stored
        ReadRegister1 = 5'd0;
        InValid = 1'b1; InRegister = 5'd0; InData = 32'hFFFF_FFFF;
        #1;
        chk("r0_ready", 32'(InReady), 32'd1);
        step();
        InValid = 1'b0;
        chk("r0_occ", 32'(Occupancy), 32'd0);
        chk("r0_regwrite", 32'(RegWrite), 32'd0);
        chk("r0_read", ReadData1, 32'd0);

        // Steady state at occupancy 2 with pointer wrap
        DrainEnable = 1'b0;
        push(5'd10, 32'hA);
        push(5'd11, 32'hB);
        DrainEnable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            InValid = 1'b1; InRegister = 5'(12 + i); InData = 32'(i * 3 + 1);
            step();
            chk("steady_occ", 32'(Occupancy), 32'd2);
        end
        InValid = 1'b0;
        repeat (3) step();
        chk("steady_drained", 32'(Occupancy), 32'd0);
        chk("steady_rf21", rf[21], 32'd28);

        // Asynchronous reset mid-drain discards pending writes
        DrainEnable = 1'b0;
        push(5'd24, 32'hA1);
        push(5'd25, 32'hA2);
        push(5'd26, 32'hA3);
        DrainEnable = 1'b1;
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_regwrite", 32'(RegWrite), 32'd0);
        chk("arst_occ", 32'(Occupancy), 32'd0);
        chk("arst_ready", 32'(InReady), 32'd1);
        step();
        Reset = 1'b0;
        repeat (3) step();
        chk("arst_rf24", rf[24], 32'd0);
        chk("arst_rf25", rf[25], 32'd0);
        chk("arst_rf26", rf[26], 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            InValid       = ($urandom_range(0, 3) != 0);
            InRegister    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                        : 5'($urandom_range(0, 7));
            InData        = $urandom;
            DrainEnable   = (((c / 150) % 3) == 0) ? ($urandom_range(0, 7) == 0)
                                                   : ($urandom_range(0, 3) != 0);
            ReadRegister1 = 5'($urandom_range(0, 7));
            ReadRegister2 = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) begin
                #2;
                Reset = 1'b1;
                step();
                Reset = 1'b0;
            end else begin
                step();
            end
        end

        InValid = 1'b0;
        DrainEnable = 1'b1;
        repeat (DEPTH + 2) step();
        for (int i = 0; i < 32; i++) chk($sformatf("final_rf%0d", i), rf[i], rf_m[i]);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
Write-side client of the MIPS 32x32 register file. It accepts write-back requests over a valid/ready handshake and buffers them in a FIFO. It drains one entry per cycle into the register file's single synchronous write port (WriteRegister/WriteData/RegWrite). Reads of pending values are forwarded, so the two asynchronous read ports never return stale data for a queued write.

Parameters:
DEPTH, 4, number of buffered write entries; power of two, 2..16.

Ports:
Clk  input  1  clock, positive edge triggered
Reset  input  1  asynchronous, active-high reset
InValid  input  1  write request present
InReady  output  1  buffer can accept a request this cycle
InRegister  input  5  destination register address of the request
InData  input  32  data of the request
DrainEnable  input  1  permits draining to the register file this cycle
WriteRegister  output  5  to register file write address
WriteData  output  32  to register file write data
RegWrite  output  1  to register file write enable
ReadRegister1  input  5  address on register file read port 1
ReadRegister2  input  5  address on register file read port 2
RegData1  input  32  ReadData1 returned by the register file
RegData2  input  32  ReadData2 returned by the register file
ReadData1  output  32  forwarded read data, port 1
ReadData2  output  32  forwarded read data, port 2
Occupancy  output  5  number of valid entries, 0..DEPTH

Behaviour:
- Storage: DEPTH entries of {5-bit address, 32-bit data}. Head and tail pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Count is held separately in Occupancy.
- Reset (async, any time including mid-drain): Occupancy=0, pointers=0, all entries invalid. RegWrite=0, InReady=1, WriteRegister=0, WriteData=0. Pending writes are discarded and never reach the register file. Storage contents need not be cleared.
- InReady = (Occupancy != DEPTH). It depends only on registered state, never on DrainEnable or InValid.
- Enqueue fires on a Clk edge when InValid & InReady.
  - InRegister==0: the handshake completes but nothing is stored (the register is hard zero). Occupancy is unchanged.
  - Otherwise: the entry is written at tail, tail+1, Occupancy+1.
- Drain: RegWrite = DrainEnable & (Occupancy!=0), combinational.
  - WriteRegister/WriteData = head entry whenever Occupancy!=0, else 0.
  - When RegWrite=1, the register file captures the head entry on the same Clk edge; the buffer pops it (head+1, Occupancy-1).
- Simultaneous enqueue and drain:
  - Non-zero enqueue: Occupancy is unchanged, both pointers advance.
  - When full, enqueue is blocked (InReady=0) even if a drain occurs that cycle. Accepted one cycle later.
  - When empty, there is no drain that cycle, so fall-through does not exist.
- Latency: a request accepted at edge N (empty buffer, DrainEnable high) drives RegWrite during cycle N..N+1. It is written to the register file at edge N+1, and RegData reflects it after N+1.
- Order: strict FIFO. Multiple writes to the same register retire in arrival order.
- Forwarding, per read port k in {1,2}, combinational:
  - Hit = a valid entry has address == ReadRegisterk and ReadRegisterk != 0.
  - On a hit, ReadDatak = data of the youngest matching entry (closest to tail); otherwise ReadDatak = RegDatak.
  - The head entry being drained this cycle still counts as a hit, because the register file is not updated until the edge.
  - An incoming, not-yet-accepted request is never forwarded.
- ReadRegisterk==0 always passes RegDatak through (expected 0).
- DrainEnable low: the buffer holds its entries. It can fill; InReady then drops and the producer stalls.

Test Plan:
- Reset, then a single write (InRegister=5, InData=0xDEADBEEF), DrainEnable=1 -> RegWrite=1 with WriteRegister=5/WriteData=0xDEADBEEF exactly one cycle after acceptance; Occupancy 1->0; regfile reg5 reads 0xDEADBEEF.
- DrainEnable=0, enqueue 4 writes to regs 1..4 -> Occupancy=4, InReady=0; a fifth request is held until DrainEnable=1, then accepted one cycle after the first pop.
- Pending writes reg7=0x11 then reg7=0x22, ReadRegister1=7, RegData1=0x0 -> ReadData1=0x22. After both retire -> ReadData1 follows RegData1 (0x22). ReadRegister2=8 passes RegData2 unchanged.
- Write to reg0 with InData=0xFFFFFFFF -> InReady handshake completes, Occupancy stays 0, RegWrite never asserts, ReadData1 for address 0 = RegData1.
- Occupancy=2 with simultaneous enqueue and drain for 10 cycles -> Occupancy stays 2, pointers wrap past DEPTH, writes retire in order with no loss or duplication.
- Assert Reset asynchronously mid-drain with Occupancy=3 -> RegWrite=0 immediately, Occupancy=0, InReady=1; no further register file writes after Reset deasserts.
